// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin arbiter/sequencer sharing the single data RAM port
// between master 0 (load/store unit) and master 1 (loader/DMA).
// Each grant is registered, presented to the RAM for one cycle, then answered with a
// registered done/rdata/err response.
// Optional build macro: DATA_RAM_ARB_ALIGN_CHECK_EN rejects misaligned and
// non-one-hot accesses before they reach the RAM.
module data_ram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_mode,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_mode,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              ram_we,
    output logic [2:0]        ram_mode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned MODE_W = 3;
    localparam logic [MODE_W-1:0] MODE_BYTE = 3'b001;
    localparam logic [MODE_W-1:0] MODE_HALF = 3'b010;
    localparam logic [MODE_W-1:0] MODE_WORD = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                last_owner;
    logic                grant;
    logic                grant_sel;

    logic                cap_we;
    logic [MODE_W-1:0]   cap_mode;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_err;

    logic                req_owner;
    logic                req_we;
    logic                req_err;
    logic [DATA_W-1:0]   rsp_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a grant in IDLE or RESP always leads into ACCESS
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = grant ? S_ACCESS : S_IDLE;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = grant ? S_ACCESS : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Arbitration and acks: a tie goes to the master that did not own the last grant
    always_comb begin
        grant     = 1'b0;
        grant_sel = 1'b0;
        if (state != S_ACCESS) begin
            if (m0_req && m1_req) begin
                grant     = 1'b1;
                grant_sel = ~last_owner;
            end else if (m0_req) begin
                grant     = 1'b1;
                grant_sel = 1'b0;
            end else if (m1_req) begin
                grant     = 1'b1;
                grant_sel = 1'b1;
            end
        end
        m0_ack = grant && !grant_sel;
        m1_ack = grant &&  grant_sel;
    end

    // Capture mux: the winning master's request fields
    always_comb begin
        cap_we    = grant_sel ? m1_we    : m0_we;
        cap_mode  = grant_sel ? m1_mode  : m0_mode;
        cap_addr  = grant_sel ? m1_addr  : m0_addr;
        cap_wdata = grant_sel ? m1_wdata : m0_wdata;
    end

`ifdef DATA_RAM_ARB_ALIGN_CHECK_EN
    // Access check: size must be one-hot and naturally aligned
    always_comb begin
        cap_err = 1'b0;
        case (cap_mode)
            MODE_BYTE: cap_err = 1'b0;
            MODE_HALF: cap_err = cap_addr[0];
            MODE_WORD: cap_err = |cap_addr[1:0];
            default:   cap_err = 1'b1;
        endcase
    end
`else
    assign cap_err = 1'b0;
`endif

    // Request register; it also drives the RAM-side buses so they hold outside ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
            req_owner  <= 1'b0;
            req_we     <= 1'b0;
            req_err    <= 1'b0;
            ram_we     <= 1'b0;
            ram_mode   <= MODE_WORD;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            ram_we <= 1'b0;
            if (grant) begin
                last_owner <= grant_sel;
                req_owner  <= grant_sel;
                req_we     <= cap_we;
                req_err    <= cap_err;
                ram_we     <= cap_we & ~cap_err;
                ram_mode   <= cap_mode;
                ram_addr   <= cap_addr;
                ram_wdata  <= cap_wdata;
            end
        end
    end

    // Load data formatting: sign-extend by size; stores and rejected accesses return 0
    always_comb begin
        rsp_data = '0;
        if (!req_we && !req_err) begin
            case (ram_mode)
                MODE_BYTE: rsp_data = {{(DATA_W-8){ram_rdata[7]}},  ram_rdata[7:0]};
                MODE_HALF: rsp_data = {{(DATA_W-16){ram_rdata[15]}}, ram_rdata[15:0]};
                default:   rsp_data = ram_rdata;
            endcase
        end
    end

    // Response registers: the owner's done/rdata/err are loaded at the end of ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_done  <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_done  <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            m0_done <= (state == S_ACCESS) && !req_owner;
            m1_done <= (state == S_ACCESS) &&  req_owner;
            if (state == S_ACCESS) begin
                if (req_owner) begin
                    m1_rdata <= rsp_data;
                    m1_err   <= req_err;
                end else begin
                    m0_rdata <= rsp_data;
                    m0_err   <= req_err;
                end
            end
        end
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and sequencer in front of the byte-lane data RAM. It shares the single RAM port between master 0 (core load/store unit) and master 1 (loader/DMA), using round-robin priority. Each accepted request is registered, driven to the RAM for exactly one cycle, and its read data returned through a registered response. Optionally, misaligned accesses are rejected before they reach the RAM.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mN_req  in  1  master N (N = 0, 1) request; held high until mN_ack.
- mN_we  in  1  1 = store, 0 = load.
- mN_mode  in  3  one-hot size: 3'b001 byte, 3'b010 half, 3'b100 word.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  DATA_W  store data, right-aligned per byte lane as the RAM expects.
- mN_ack  out  1  one-cycle pulse; request accepted this cycle.
- mN_done  out  1  one-cycle pulse; response valid.
- mN_rdata  out  DATA_W  sign-extended load data; valid with mN_done, 0 for stores.
- mN_err  out  1  valid with mN_done; access was rejected.
- ram_we  out  1  RAM write enable.
- ram_mode  out  3  RAM size select.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Grant is decided in IDLE or RESP when any mN_req is high.
  - A grant asserts mN_ack combinationally in that cycle.
  - It captures we/mode/addr/wdata and the owner ID into a request register, then moves to ACCESS.
- Arbitration:
  - With a single requester, that requester wins.
  - With both requesting, the master not in last_owner wins.
  - last_owner updates on every grant and resets to 1, so m0 wins the first tie.
- ACCESS:
  - ram_addr, ram_mode and ram_wdata come from the request register.
  - ram_we = registered we AND NOT err_flag.
  - ram_rdata is captured into the response register at the end of the cycle. Stores capture 0.
  - Next state is RESP.
- RESP:
  - mOwner_done pulses with the registered rdata and err.
  - If a new request is granted in this cycle, next state is ACCESS; otherwise IDLE.
- Outside ACCESS: ram_we = 0 and the RAM-side buses hold their last registered values.
- err_flag is computed at capture:
  - mode not one-hot → error;
  - half with addr[0] = 1 → error;
  - word with addr[1:0] ≠ 0 → error.
- An erroring access produces no RAM write, rdata = 0 and err = 1.
- Changes on mN_* inputs after ack do not affect the in-flight access.

## Timing
- Reset values: state IDLE, all ack/done/err 0, rdata 0, ram_we 0, ram_addr/ram_wdata 0, ram_mode 3'b100, last_owner 1.
- Latency: request accepted in cycle T (ack), RAM accessed in T+1, done in T+2.
- Write commits on the clk edge ending T+1.
- Back-to-back throughput is one access per 2 cycles, because a grant in RESP overlaps the previous response.
- Simultaneous done for one master and ack for the other in the same cycle is legal.
- A master may re-request in its own done cycle and be acked in that cycle, subject to round-robin.
- Reset asserted mid-ACCESS: ram_we drops immediately (async). The in-flight access is lost: no done pulse and no partial write after reset.

## Configuration
- DATA_RAM_ARB_ALIGN_CHECK_EN defined: alignment and one-hot checks active as described.
- Not defined: err_flag is forced to 0 and mN_err is always 0. Every access is forwarded unchanged, and misaligned sizes take whatever lane behaviour the RAM decode gives.

## Test plan
- Reset, then m0 word store 0xDEADBEEF to 0x10 → ack at T, ram_we = 1 only at T+1, m0_done at T+2 with err = 0. A following m0 word load from 0x10 returns 0xDEADBEEF.
- m1 byte load from 0x13 after a word store of 0x80FF0000 to 0x10 → m1_rdata = 0xFFFFFF80. Half load from 0x12 → 0xFFFF80FF.
- m0 and m1 request in the same cycle, continuously for 6 grants:
  - acks alternate m0, m1, m0, …;
  - each done arrives 2 cycles after its ack;
  - a grant occurs every 2 cycles.
- With DATA_RAM_ARB_ALIGN_CHECK_EN, word store to 0x11 → done with err = 1, rdata = 0, ram_we never asserted, and RAM contents unchanged. Without the macro, err = 0 and ram_we is asserted.
- Reset pulsed during ACCESS of a store → ram_we 0 within the reset cycle, no done, FSM in IDLE, last_owner = 1 after release.
- m0 changes addr/wdata one cycle after ack → the RAM sees the originally captured values.
